// File: rtl/piso_shift_tx_if.sv
// Handshake and serial-output bundle for the parallel-in/serial-out transmitter.
// The master side supplies words; the slave side is the transmitter itself.
interface piso_shift_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             sout;
    logic             sout_bar;
    logic             busy;
    logic             done;

    modport master (
        output din, load,
        input  ready, sout, sout_bar, busy, done
    );

    modport slave (
        input  din, load,
        output ready, sout, sout_bar, busy, done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: captures a WIDTH-bit word on load and
// shifts it out one bit per clock, MSB or LSB first, with a done pulse at the end.
//
// state | meaning
// IDLE  | waiting for load; ready high, sout parked at 0
// SHIFT | frame bits on sout, one per cycle; load ignored
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic             clk,
    input logic             rst,
    piso_shift_tx_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             sout_q;
    logic             sout_bar_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] rest;
    logic             head;

    // The same head/remainder split serves both the capture edge and every shift edge.
    always_comb begin
        src  = (state == IDLE) ? bus.din : shreg;
        head = 1'b0;
        rest = '0;
        if (MSB_FIRST) begin
            head = src[WIDTH-1];
            rest = {src[WIDTH-2:0], 1'b0};
        end else begin
            head = src[0];
            rest = {1'b0, src[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            sout_q     <= 1'b0;
            sout_bar_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.load) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        shreg      <= rest;
                        sout_q     <= head;
                        sout_bar_q <= ~head;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        shreg      <= '0;
                        sout_q     <= 1'b0;
                        sout_bar_q <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        ready_q    <= 1'b1;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        shreg      <= rest;
                        sout_q     <= head;
                        sout_bar_q <= ~head;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sout     = sout_q;
    assign bus.sout_bar = sout_bar_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ready    = ready_q;
endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: three instances (8-bit MSB-first, 8-bit LSB-first,
// 2-bit MSB-first) driven by directed and random loads, checked against a frame-level model.
module tb_piso_shift_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_shift_tx_if #(.WIDTH(8)) if0 ();
    piso_shift_tx_if #(.WIDTH(8)) if1 ();
    piso_shift_tx_if #(.WIDTH(2)) if2 ();

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    piso_shift_tx #(.WIDTH(2), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));

    logic [31:0] dv [3];
    logic        ld [3];

    assign if0.din  = dv[0][7:0];
    assign if1.din  = dv[1][7:0];
    assign if2.din  = dv[2][1:0];
    assign if0.load = ld[0];
    assign if1.load = ld[1];
    assign if2.load = ld[2];

    int W  [3] = '{8, 8, 2};
    bit MF [3] = '{1'b1, 1'b0, 1'b1};

    bit bq [3][$];
    int start   [3];
    int free_at [3];
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, int i, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc%0d got %0h expected %0h", nm, i, cyc, got, exp);
        end
    endtask

    task automatic flush_model();
        for (int i = 0; i < 3; i++) begin
            bq[i].delete();
            start[i]   = -1000;
            free_at[i] = 0;
        end
    endtask

    // Frame-level model: a load seen while idle schedules W bits then one done cycle.
    always @(posedge clk) begin
        cyc++;
        if (rst) flush_model();
        else begin
            for (int i = 0; i < 3; i++) begin
                if (ld[i] && cyc >= free_at[i]) begin
                    start[i]   = cyc;
                    free_at[i] = cyc + W[i] + 1;
                    for (int j = 0; j < W[i]; j++)
                        bq[i].push_back(MF[i] ? dv[i][W[i]-1-j] : dv[i][j]);
                end
            end
        end
    end

    task automatic mon(int i, logic busy, logic done, logic so, logic sb, logic rdy);
        bit eb, ed, es;
        eb = (cyc >= start[i]) && (cyc < start[i] + W[i]);
        ed = (cyc == start[i] + W[i]);
        es = 1'b0;
        if (eb) begin
            chk("bits_pending", i, 32'(bq[i].size() != 0), 1);
            if (bq[i].size() != 0) es = bq[i].pop_front();
        end
        chk("busy", i, busy, eb);
        chk("done", i, done, ed);
        chk("ready", i, rdy, !eb);
        chk("sout", i, so, es);
        chk("sout_bar", i, sb, !es);
        chk("busy_done_excl", i, busy && done, 0);
    endtask

    always @(negedge clk) begin
        mon(0, if0.busy, if0.done, if0.sout, if0.sout_bar, if0.ready);
        mon(1, if1.busy, if1.done, if1.sout, if1.sout_bar, if1.ready);
        mon(2, if2.busy, if2.done, if2.sout, if2.sout_bar, if2.ready);
    end

    task automatic rst_chk(int i, logic busy, logic done, logic so, logic sb, logic rdy);
        chk("async_rst_busy", i, busy, 0);
        chk("async_rst_done", i, done, 0);
        chk("async_rst_sout", i, so, 0);
        chk("async_rst_sout_bar", i, sb, 1);
        chk("async_rst_ready", i, rdy, 1);
    endtask

    // Reset pulse placed well inside a cycle; outputs must settle before the next edge.
    task automatic async_rst_pulse();
        @(posedge clk);
        #2 rst = 1'b1;
        flush_model();
        #1;
        rst_chk(0, if0.busy, if0.done, if0.sout, if0.sout_bar, if0.ready);
        rst_chk(1, if1.busy, if1.done, if1.sout, if1.sout_bar, if1.ready);
        rst_chk(2, if2.busy, if2.done, if2.sout, if2.sout_bar, if2.ready);
        #1 rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            dv[i] = '0;
            ld[i] = 1'b0;
        end
        flush_model();
        rst = 1'b1;

        // loads presented while reset is held must be ignored
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                ld[i] = 1'b1;
                dv[i] = $urandom;
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) ld[i] = 1'b0;
        repeat (2) @(negedge clk);

        dv[0] = 32'hA5;
        dv[1] = 32'h01;
        dv[2] = 32'h2;
        for (int i = 0; i < 3; i++) ld[i] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) ld[i] = 1'b0;
        repeat (12) @(negedge clk);

        // load held high: FF then 00 back to back
        dv[0] = 32'hFF;
        ld[0] = 1'b1;
        @(negedge clk);
        dv[0] = 32'h00;
        repeat (20) @(negedge clk);
        ld[0] = 1'b0;
        repeat (12) @(negedge clk);

        // load and din changes during a frame are ignored
        dv[0] = 32'hF0;
        ld[0] = 1'b1;
        @(negedge clk);
        ld[0] = 1'b0;
        repeat (2) @(negedge clk);
        dv[0] = 32'h0F;
        ld[0] = 1'b1;
        repeat (4) @(negedge clk);
        ld[0] = 1'b0;
        repeat (8) @(negedge clk);

        // abort 8'hAA during its fourth bit, then send a fresh frame
        dv[0] = 32'hAA;
        ld[0] = 1'b1;
        @(negedge clk);
        ld[0] = 1'b0;
        repeat (2) @(negedge clk);
        async_rst_pulse();
        @(negedge clk);
        dv[0] = 32'h81;
        ld[0] = 1'b1;
        @(negedge clk);
        ld[0] = 1'b0;
        repeat (12) @(negedge clk);

        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                ld[i] = ($urandom % 3) == 0;
                dv[i] = $urandom;
            end
            if (($urandom % 120) == 0) async_rst_pulse();
        end

        @(negedge clk);
        for (int i = 0; i < 3; i++) ld[i] = 1'b0;
        repeat (15) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("drain", i, bq[i].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
